// File: rtl/pea_pkg.sv
// Shared definitions for the PE functional units: datapath width, the
// multiply-accumulate FSM states and the accumulator width.
package pea_pkg;

  // Operand and result width of the PE datapath.
  localparam int N_BITS = 32;

  // Accumulator width: wide enough that (2^N-1)^2 + (2^N-1) never wraps.
  localparam int MUL_ACC_W = 2 * N_BITS + 1;

  // Sequencer states of the shift-add multiply-accumulate unit.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage : pea_pkg

// File: rtl/r_mul_cell.sv
// One shift-add step: conditionally add the pre-shifted multiplicand into
// the accumulator. Purely combinational, the mirror of the divider cell.
module r_mul_cell
  import pea_pkg::*;
(
  input  logic [MUL_ACC_W-1:0] acc_i,
  input  logic [MUL_ACC_W-1:0] a_sh_i,
  input  logic                 bit_i,
  output logic [MUL_ACC_W-1:0] acc_o
);

  // Add the shifted multiplicand only when the current multiplier bit is set.
  always_comb begin
    acc_o = acc_i;
    if (bit_i) begin
      acc_o = acc_i + a_sh_i;
    end
  end

endmodule : r_mul_cell

// File: rtl/r_mul_seq.sv
// Multicycle unsigned multiply-accumulate: res = a*b + c, one multiplier bit
// per cycle. Latency is fixed (N_BITS step cycles plus one cycle to register
// the result), independent of operand values, so it can also rebuild a
// dividend from divider outputs for self-checking.
module r_mul_seq
  import pea_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic [N_BITS-1:0] c_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_BITS-1:0] res_o,
  output logic              ovf_o
);

  // The counter must be able to hold N_BITS itself: after the last bit has
  // been consumed it reads N_BITS and the next cycle registers the result.
  localparam int CNT_W = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS);

  mul_state_e           r_state;
  logic [MUL_ACC_W-1:0] r_acc;
  logic [MUL_ACC_W-1:0] r_a_sh;   // multiplicand, shifted left one place per step
  logic [N_BITS-1:0]    r_b;      // multiplier, shifted right; bit 0 is the active bit
  logic [CNT_W-1:0]     r_cnt;
  logic [N_BITS-1:0]    r_res;
  logic                 r_ovf;
  logic                 r_valid;
  logic                 r_ready;

  logic [MUL_ACC_W-1:0] w_acc_next;

  r_mul_cell u_cell (
    .acc_i  (r_acc),
    .a_sh_i (r_a_sh),
    .bit_i  (r_b[0]),
    .acc_o  (w_acc_next)
  );

  // Sequencer: accept operands, step N_BITS times, then present the result
  // until the consumer takes it. All outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= MUL_IDLE;
      r_acc   <= '0;
      r_a_sh  <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (valid_i && r_ready) begin
            r_a_sh  <= {{(MUL_ACC_W-N_BITS){1'b0}}, a_i};
            r_b     <= b_i;
            r_acc   <= {{(MUL_ACC_W-N_BITS){1'b0}}, c_i};
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (r_cnt == CNT_LAST) begin
            // Every multiplier bit consumed: register the result.
            r_res   <= r_acc[N_BITS-1:0];
            r_ovf   <= |r_acc[MUL_ACC_W-1:N_BITS];
            r_valid <= 1'b1;
            r_state <= MUL_DONE;
          end else begin
            r_acc   <= w_acc_next;
            r_a_sh  <= r_a_sh << 1;
            r_b     <= r_b >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        MUL_DONE: begin
          // Hold the result under backpressure; no accept in the same cycle.
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= MUL_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= MUL_IDLE;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign res_o   = r_res;
  assign ovf_o   = r_ovf;

endmodule : r_mul_seq
